// File: rtl/iex_shift_unit.sv
// iex_shift_unit: multi-cycle shift/rotate unit for the execute stage.
// The shift amount is resolved as log2(DATA_WIDTH) binary stages, LSB first,
// with STAGES_PER_CYCLE stages applied per RUN cycle. One operation in flight.
// Build option: define IEX_SHIFT_ROTATE_EN to make ROL/ROR legal; without it
// those codes are reported as illegal and no rotate logic is built.
module iex_shift_unit #(
   parameter int DATA_WIDTH       = 32,
   parameter int STAGES_PER_CYCLE = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          in_vld,
   output logic                          in_rdy,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic [$clog2(DATA_WIDTH)-1:0] in_shamt,
   input  logic [2:0]                    in_op,
   input  logic [4:0]                    in_rd,
   output logic                          out_vld,
   input  logic                          out_rdy,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [4:0]                    out_rd,
   output logic                          out_err,
   output logic                          busy
);

   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
   localparam int PASSES      = (SHAMT_WIDTH + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
   localparam int CNT_W       = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b011;
`ifdef IEX_SHIFT_ROTATE_EN
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_n;
   logic [CNT_W-1:0]       cnt;
   logic [SHAMT_WIDTH-1:0] shamt_r;
   logic [2:0]             op_r;
   logic                   accept;
   logic                   in_legal;
   logic [DATA_WIDTH-1:0]  pass_data;
   logic [DATA_WIDTH-1:0]  stage_data;

   function automatic logic op_legal(input logic [2:0] op);
      logic ok;
      case (op)
         OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef IEX_SHIFT_ROTATE_EN
         OP_ROL, OP_ROR:         ok = 1'b1;
`endif
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   // One binary stage by a fixed amount. For SRA the working value keeps the
   // accepted operand's MSB in place, so sign-filling from the current MSB is
   // the same as filling from the original sign bit.
   function automatic logic [DATA_WIDTH-1:0] shift_stage(
      input logic [DATA_WIDTH-1:0] d,
      input logic [2:0]            op,
      input int                    amt
   );
      logic signed [DATA_WIDTH-1:0] sd;
      logic        [DATA_WIDTH-1:0] r;
      sd = d;
      r  = d;
      case (op)
         OP_SLL: r = d << amt;
         OP_SRL: r = d >> amt;
         OP_SRA: r = sd >>> amt;
`ifdef IEX_SHIFT_ROTATE_EN
         OP_ROL: r = (d << amt) | (d >> (DATA_WIDTH - amt));
         OP_ROR: r = (d >> amt) | (d << (DATA_WIDTH - amt));
`endif
         default: r = d;
      endcase
      return r;
   endfunction

   // Handshake and next-state decode; flush overrides every handshake.
   always_comb begin
      in_rdy   = ~flush & ((state == IDLE) | ((state == DONE) & out_rdy));
      accept   = in_vld & in_rdy;
      in_legal = op_legal(in_op);
      state_n  = state;
      if (flush) begin
         state_n = IDLE;
      end else if (accept) begin
         state_n = (~in_legal | (in_shamt == '0)) ? DONE : RUN;
      end else begin
         case (state)
            RUN:     if (cnt == LAST_PASS) state_n = DONE;
            DONE:    if (out_rdy)          state_n = IDLE;
            default: state_n = state;
         endcase
      end
   end

   // Stages of the current pass; the shamt register is shifted down each pass
   // so the pass always consumes its low STAGES_PER_CYCLE bits.
   always_comb begin
      pass_data  = out_data;
      stage_data = out_data;
      for (int p = 0; p < PASSES; p++) begin
         if (cnt == CNT_W'(p)) begin
            stage_data = out_data;
            for (int j = 0; j < STAGES_PER_CYCLE; j++) begin
               if ((p * STAGES_PER_CYCLE + j) < SHAMT_WIDTH) begin
                  if (shamt_r[j]) begin
                     stage_data = shift_stage(stage_data, op_r, 1 << (p * STAGES_PER_CYCLE + j));
                  end
               end
            end
            pass_data = stage_data;
         end
      end
   end

   // State register, pass counter and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         out_vld <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         out_vld <= (state_n == DONE);
         busy    <= (state_n != IDLE);
         if (accept) begin
            cnt <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Operand capture and per-pass update of the working/result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_rd   <= '0;
         out_err  <= 1'b0;
         op_r     <= '0;
         shamt_r  <= '0;
      end else if (flush) begin
         out_err <= 1'b0;
      end else if (accept) begin
         out_rd  <= in_rd;
         op_r    <= in_op;
         shamt_r <= in_shamt;
         if (!in_legal) begin
            out_data <= '0;
            out_err  <= 1'b1;
         end else begin
            out_data <= in_data;
            out_err  <= 1'b0;
         end
      end else if (state == RUN) begin
         out_data <= pass_data;
         shamt_r  <= shamt_r >> STAGES_PER_CYCLE;
      end
   end

endmodule

// File: doc/iex_shift_unit.md
# iex_shift_unit

Parametrised multi-cycle shift/rotate unit for the execute stage, the successor to the single-cycle ALU shifter. It accepts one operation at a time over a valid/ready handshake and resolves the shift amount as log2(DATA_WIDTH) binary stages, applying STAGES_PER_CYCLE stages per clock. Each result is returned with the destination register tag and an error flag. Latency is traded against logic depth per cycle so the unit can close timing at higher core clocks.

## Interface
- DATA_WIDTH, 32: operand width. Must be a power of two and at least 8.
- STAGES_PER_CYCLE, 1: binary shift stages applied per RUN cycle. Range is 1 to SHAMT_WIDTH.
- Derived localparams (not overridable):
  - SHAMT_WIDTH = $clog2(DATA_WIDTH).
  - PASSES = ceil(SHAMT_WIDTH / STAGES_PER_CYCLE).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any operation held in the unit
- in_vld  in  1  request valid
- in_rdy  out  1  unit can accept a request
- in_data  in  DATA_WIDTH  operand
- in_shamt  in  SHAMT_WIDTH  shift amount
- in_op  in  3  operation: 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; all other codes are illegal
- in_rd  in  5  destination tag, returned unchanged
- out_vld  out  1  result valid
- out_rdy  in  1  consumer accepts the result
- out_data  out  DATA_WIDTH  result
- out_rd  out  5  tag of the result
- out_err  out  1  request was illegal
- busy  out  1  state is not IDLE

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- in_rdy = ~flush & (IDLE | (DONE & out_rdy)). This is combinational.
- Accept occurs on in_vld & in_rdy:
  - Latch data, shamt, op and rd; clear the stage counter.
  - Illegal op: go to DONE with out_err=1 and out_data=0.
  - in_shamt==0: go to DONE with out_data=in_data and out_err=0.
  - Otherwise: go to RUN.
- RUN, each cycle:
  - Apply stages k = cnt*STAGES_PER_CYCLE up to min(next boundary, SHAMT_WIDTH)-1, in LSB-first order.
  - Stage k shifts by 2^k when latched shamt[k]=1.
  - After PASSES cycles, go to DONE.
- Shift rules:
  - SLL and SRL zero-fill.
  - SRA fills with bit DATA_WIDTH-1 of the accepted operand.
  - ROL and ROR wrap bits around modulo DATA_WIDTH.
  - Output width always equals DATA_WIDTH; no bits are carried out.
- DONE:
  - out_vld=1. out_data, out_rd and out_err are held stable until out_rdy=1.
  - On handshake, go to IDLE, or accept a new request in the same cycle if in_vld=1 (back-to-back).
- flush:
  - From any state, go to IDLE on the next edge.
  - The held result is dropped and out_vld deasserts.
  - A request presented in the flush cycle is not accepted.
  - flush has priority over every handshake.
- rst_n low, at any time including mid-RUN:
  - state=IDLE; out_vld, out_err and busy are 0.
  - out_data and out_rd are 0.
  - in_rdy=1 once flush=0.

## Timing
- Accept at edge E:
  - Normal op: RUN occupies PASSES cycles; out_vld is first high in the cycle after edge E+PASSES.
  - Example: DATA_WIDTH=32, STAGES_PER_CYCLE=1 gives PASSES=5, so out_vld rises 6 cycles after accept.
  - Example: STAGES_PER_CYCLE=5 gives latency 2.
- Illegal op or shamt==0: out_vld is high in the cycle after accept (latency 1).
- Throughput: one operation per PASSES+1 cycles when back-to-back with out_rdy=1.
- in_rdy is 0 throughout RUN and during DONE while out_rdy=0.
- All outputs except in_rdy are registered.

## Configuration
- IEX_SHIFT_ROTATE_EN defined: ROL and ROR are legal and executed as specified.
- IEX_SHIFT_ROTATE_EN undefined:
  - op codes 100 and 101 are illegal: latency 1, out_err=1, out_data=0.
  - The rotate datapath is not synthesised.

## Test plan
- SLL, W=32, S=1: in_data=0x00000001, shamt=31 -> out_data=0x80000000, out_vld 6 cycles after accept, out_rd echoes in_rd.
- SRA on 0x80000000, shamt=4 -> 0xF8000000. SRL on the same operand and shamt -> 0x08000000. Repeat with S=5 -> latency 2 and identical results.
- ROR on 0x000000F1, shamt=4:
  - With IEX_SHIFT_ROTATE_EN -> 0x1000000F.
  - Without it -> out_err=1, out_data=0, latency 1.
- Hold out_rdy=0 for 3 cycles in DONE -> outputs stable and in_rdy=0. Then assert out_rdy with in_vld=1 in the same cycle -> result retired and new request accepted; no idle cycle.
- flush in the 2nd RUN cycle -> out_vld never rises and in_rdy=1 the next cycle. Separately, rst_n low mid-RUN -> all outputs 0 immediately.
- op=010 -> out_err=1, out_data=0, latency 1. shamt=0 with SLL and data 0xDEADBEEF -> 0xDEADBEEF, latency 1.
